bri_gate_drv: RTL and testbench
===============================

Name: bri_gate_drv

Overview:
- Consumer end of the bridge drive interface: takes the up/down phase commands from the bridge state machine and produces the four H-bridge gate signals for the NMR transmit coil bridge.
- Every gate turn-on is preceded by a programmable all-off dead time.
- Illegal up/down combinations (both high) and over-long conduction are detected, and the bridge is latched off in a fault state until software clears it.

Parameters:
DT_W, 4, width of the dead-time count input dead_cyc.
ON_W, 10, width of the maximum on-time input max_on and of the internal on-time counter.

Ports:
clk_dds  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  synchronous drive enable; 0 forces the bridge off (same role as i[0] upstream).
up  input  1  positive-phase command from the bridge state machine.
down  input  1  negative-phase command from the bridge state machine.
dead_cyc  input  DT_W  dead time; all-off interval = dead_cyc+1 clk_dds cycles.
max_on  input  ON_W  maximum continuous conduction in cycles; 0 disables the watchdog.
fault_clr  input  1  fault acknowledge.
q_ap  output  1  gate, leg A high side.
q_an  output  1  gate, leg A low side.
q_bp  output  1  gate, leg B high side.
q_bn  output  1  gate, leg B low side.
fault  output  1  latched fault flag.
fault_code  output  2  00 none, 01 illegal up&down, 10 on-time watchdog.

Behaviour:
- Input register: up and down are sampled into up_r/down_r every cycle. req = {up_r, down_r}: 10 = POS, 01 = NEG, 00 = OFF, 11 = illegal.
- States: OFF, DEAD, POS, NEG, FAULT. DEAD holds a target register (OFF/POS/NEG) and a DT_W-bit down-counter.
- Gate outputs are registered and updated on the same edge as the state register.
  - POS: q_ap=1, q_bn=1, others 0.
  - NEG: q_bp=1, q_an=1, others 0.
  - OFF, DEAD, FAULT: all four gates 0.
  - q_ap&q_an and q_bp&q_bn are never 1 together in any state.
- Reset (rst=1, asynchronous): state OFF, all gates 0, fault=0, fault_code=00, counters 0, up_r/down_r 0.
- Priority per edge, highest first: rst > FAULT hold > en=0 > illegal req > watchdog > normal transitions.
- en=0: next state OFF and counters cleared; req is ignored, so no illegal detection. FAULT is not left via en=0.
- OFF: req POS or NEG -> DEAD with target=req, cnt=dead_cyc. Req OFF -> stay in OFF.
- DEAD:
  - cnt!=0 -> cnt-1.
  - cnt==0 -> go to target.
  - A req change while in DEAD updates target without reloading cnt.
  - DEAD lasts exactly dead_cyc+1 cycles.
- POS/NEG:
  - req equal to the current state -> stay.
  - Any other legal req -> DEAD with target=req, cnt=dead_cyc. Gates drop on that same edge.
- Illegal req (11) in OFF, DEAD, POS or NEG -> FAULT, fault_code=01.
- Watchdog:
  - on_cnt is loaded with 1 on the edge entering POS/NEG and incremented on each edge spent in POS/NEG.
  - If max_on!=0 and on_cnt==max_on at an edge -> FAULT, fault_code=10. Gates are therefore on for exactly max_on cycles.
  - With max_on=0, on_cnt saturates at all-ones and no fault is raised.
- FAULT:
  - fault=1, all gates 0.
  - Exit to OFF only when fault_clr=1 and req==00 on the same edge; fault and fault_code clear on that edge.
  - fault_clr with req!=00 is ignored.
  - Only the first fault cause is recorded; the code is held while in FAULT.
- Latency: up first sampled high at edge k (from OFF, en=1) -> DEAD at edge k+1 -> POS gates high at edge k+2+dead_cyc.
- dead_cyc and max_on are sampled live. Changing them mid-interval affects only subsequent loads and compares; cnt is not reloaded.

Test Plan:
1. rst pulse mid-POS -> gates 0 immediately (asynchronous), fault=0. After release with up=1, dead_cyc=3: q_ap/q_bn rise 5 edges after up is first sampled.
2. dead_cyc=2, up=1 for 20 cycles then down=1 directly -> q_ap/q_bn fall on the edge after down is registered; exactly 3 all-off cycles follow; then q_bp/q_an high.
3. Alternating up/down every 8 cycles with dead_cyc=0 -> exactly 1 all-off cycle at each reversal; assertion that no leg ever has both high and low gates on.
4. up=down=1 for one cycle during POS -> FAULT, fault_code=01, gates 0. fault_clr=1 while up=1 -> stays in FAULT. fault_clr=1 with up=down=0 -> OFF, fault=0.
5. max_on=6, up held high -> gates on exactly 6 cycles, then fault_code=10. Same stimulus with max_on=0 -> POS held indefinitely.
6. en=0 during DEAD with up=1 -> OFF next edge, gates stay 0. en=0 with up=down=1 -> no fault. en=0 while in FAULT -> fault stays 1.

Source files
------------

// File: rtl/bri_gate_drv.sv
// H-bridge gate driver for the NMR transmit coil: dead-time insertion,
// shoot-through protection and latched fault handling.
module bri_gate_drv #(
    parameter int DT_W = 4,
    parameter int ON_W = 10
) (
    input  logic            clk_dds,
    input  logic            rst,
    input  logic            en,
    input  logic            up,
    input  logic            down,
    input  logic [DT_W-1:0] dead_cyc,
    input  logic [ON_W-1:0] max_on,
    input  logic            fault_clr,
    output logic            q_ap,
    output logic            q_an,
    output logic            q_bp,
    output logic            q_bn,
    output logic            fault,
    output logic [1:0]      fault_code
);

    typedef enum logic [2:0] {
        S_OFF,
        S_DEAD,
        S_POS,
        S_NEG,
        S_FAULT
    } state_t;

    localparam logic [1:0] R_OFF = 2'b00;
    localparam logic [1:0] R_NEG = 2'b01;
    localparam logic [1:0] R_POS = 2'b10;
    localparam logic [1:0] R_ILL = 2'b11;

    // gate order {ap, an, bp, bn}
    localparam logic [3:0] G_OFF = 4'b0000;
    localparam logic [3:0] G_POS = 4'b1001;
    localparam logic [3:0] G_NEG = 4'b0110;

    state_t          state;
    logic            up_r;
    logic            down_r;
    logic [DT_W-1:0] cnt;
    logic [1:0]      target;
    logic [ON_W-1:0] on_cnt;
    logic [3:0]      gate;
    logic [1:0]      req;
    logic [1:0]      cur_req;
    logic            conducting;
    logic            wd_hit;

    assign req        = {up_r, down_r};
    assign conducting = (state == S_POS) || (state == S_NEG);
    assign cur_req    = (state == S_POS) ? R_POS :
                        (state == S_NEG) ? R_NEG : R_OFF;
    assign wd_hit     = conducting && (max_on != '0) && (on_cnt == max_on);

    assign {q_ap, q_an, q_bp, q_bn} = gate;

    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            state      <= S_OFF;
            up_r       <= 1'b0;
            down_r     <= 1'b0;
            cnt        <= '0;
            target     <= R_OFF;
            on_cnt     <= '0;
            gate       <= G_OFF;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            up_r   <= up;
            down_r <= down;
            if (state == S_FAULT) begin
                if (fault_clr && req == R_OFF) begin
                    state      <= S_OFF;
                    fault      <= 1'b0;
                    fault_code <= 2'b00;
                end
            end else if (!en) begin
                state  <= S_OFF;
                cnt    <= '0;
                on_cnt <= '0;
                target <= R_OFF;
                gate   <= G_OFF;
            end else if (req == R_ILL) begin
                state      <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= 2'b01;
                gate       <= G_OFF;
            end else if (wd_hit) begin
                state      <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= 2'b10;
                gate       <= G_OFF;
            end else begin
                unique case (state)
                    S_OFF: begin
                        if (req != R_OFF) begin
                            state  <= S_DEAD;
                            target <= req;
                            cnt    <= dead_cyc;
                        end
                    end
                    S_DEAD: begin
                        // target tracks req; the count is never reloaded here
                        target <= req;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            on_cnt <= ON_W'(1);
                            case (target)
                                R_POS: begin
                                    state <= S_POS;
                                    gate  <= G_POS;
                                end
                                R_NEG: begin
                                    state <= S_NEG;
                                    gate  <= G_NEG;
                                end
                                default: state <= S_OFF;
                            endcase
                        end
                    end
                    S_POS, S_NEG: begin
                        if (req == cur_req) begin
                            if (on_cnt != '1) on_cnt <= on_cnt + 1'b1;
                        end else begin
                            state  <= S_DEAD;
                            target <= req;
                            cnt    <= dead_cyc;
                            gate   <= G_OFF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bri_gate_drv.sv
// Scoreboard bench for bri_gate_drv: reference model pushes expected
// outputs per edge, monitor pops and compares on the falling edge.
module tb_bri_gate_drv;

    localparam int DT_W   = 4;
    localparam int ON_W   = 10;
    localparam int ON_MAX = (1 << ON_W) - 1;

    localparam int M_OFF  = 0;
    localparam int M_DEAD = 1;
    localparam int M_POS  = 2;
    localparam int M_NEG  = 3;
    localparam int M_FLT  = 4;

    logic            clk_dds = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            up = 1'b0;
    logic            down = 1'b0;
    logic [DT_W-1:0] dead_cyc = '0;
    logic [ON_W-1:0] max_on = '0;
    logic            fault_clr = 1'b0;
    logic            q_ap, q_an, q_bp, q_bn, fault;
    logic [1:0]      fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] sb[$];

    bri_gate_drv #(.DT_W(DT_W), .ON_W(ON_W)) dut (
        .clk_dds   (clk_dds),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .down      (down),
        .dead_cyc  (dead_cyc),
        .max_on    (max_on),
        .fault_clr (fault_clr),
        .q_ap      (q_ap),
        .q_an      (q_an),
        .q_bp      (q_bp),
        .q_bn      (q_bn),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk_dds = ~clk_dds;

    // Reference model: bridge mode, remaining dead cycles, cycles conducted.
    int         m_mode = M_OFF;
    int         m_left = 0;
    int         m_tgt = M_OFF;
    int         m_on = 0;
    int         m_code = 0;
    bit         m_u = 0;
    bit         m_d = 0;

    function automatic int req_mode(bit u, bit d);
        if (u && !d) return M_POS;
        if (!u && d) return M_NEG;
        return M_OFF;
    endfunction

    function automatic logic [6:0] expect_vec();
        logic [6:0] e;
        e[6]   = (m_mode == M_POS);
        e[5]   = (m_mode == M_NEG);
        e[4]   = (m_mode == M_NEG);
        e[3]   = (m_mode == M_POS);
        e[2]   = (m_mode == M_FLT);
        e[1:0] = m_code[1:0];
        return e;
    endfunction

    function automatic void model_step();
        int rm;
        if (rst) begin
            m_mode = M_OFF; m_left = 0; m_tgt = M_OFF;
            m_on = 0; m_code = 0; m_u = 0; m_d = 0;
        end else begin
            rm = req_mode(m_u, m_d);
            if (m_mode == M_FLT) begin
                if (fault_clr && !m_u && !m_d) begin
                    m_mode = M_OFF;
                    m_code = 0;
                end
            end else if (!en) begin
                m_mode = M_OFF; m_left = 0; m_on = 0; m_tgt = M_OFF;
            end else if (m_u && m_d) begin
                m_mode = M_FLT;
                m_code = 1;
            end else if ((m_mode == M_POS || m_mode == M_NEG)
                         && max_on != 0 && m_on == int'(max_on)) begin
                m_mode = M_FLT;
                m_code = 2;
            end else if (m_mode == M_OFF) begin
                if (rm != M_OFF) begin
                    m_mode = M_DEAD; m_tgt = rm; m_left = int'(dead_cyc);
                end
            end else if (m_mode == M_DEAD) begin
                if (m_left == 0) begin
                    m_mode = m_tgt;
                    m_on = 1;
                end else begin
                    m_left--;
                    m_tgt = rm;
                end
            end else begin
                if (rm == m_mode) begin
                    if (m_on < ON_MAX) m_on++;
                end else begin
                    m_mode = M_DEAD; m_tgt = rm; m_left = int'(dead_cyc);
                end
            end
            m_u = up;
            m_d = down;
        end
        sb.push_back(expect_vec());
    endfunction

    task automatic check(input string nm, input logic [6:0] act,
                         input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {q_ap, q_an, q_bp, q_bn, fault, fault_code};
    endfunction

    always @(posedge clk_dds) model_step();

    always @(negedge clk_dds) begin
        if (sb.size() > 0) check("scoreboard", dut_vec(), sb.pop_front());
    end

    always @(negedge clk_dds) begin
        assert (!(q_ap && q_an) && !(q_bp && q_bn))
        else $error("shoot-through on a leg at %0t", $time);
    end

    task automatic drive(input logic u, input logic d, input int n);
        up   = u;
        down = d;
        repeat (n) @(negedge clk_dds);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_dds);
        check("reset_state", dut_vec(), 7'b0);
        rst = 1'b0;
        en  = 1'b1;
        dead_cyc = 4'd3;

        // latency from first sample of up to POS gates
        up = 1'b1;
        n = 0;
        @(posedge clk_dds);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_dds);
            #1;
            n++;
            if (q_ap) break;
        end
        check("latency", 7'(n), 7'd5);
        @(negedge clk_dds);
        drive(1, 0, 4);

        // asynchronous reset while conducting
        #2 rst = 1'b1;
        #1 check("async_rst", dut_vec(), 7'b0);
        @(negedge clk_dds);
        rst = 1'b0;
        drive(1, 0, 12);

        // POS -> NEG reversal with dead_cyc=2
        dead_cyc = 4'd2;
        drive(1, 0, 20);
        drive(0, 1, 15);

        // alternating with single-cycle dead time
        dead_cyc = 4'd0;
        for (int i = 0; i < 6; i++) drive(i[0] ? 1'b0 : 1'b1, i[0], 8);

        // illegal request, blocked clear, proper clear
        drive(1, 0, 10);
        drive(1, 1, 1);
        drive(1, 0, 2);
        check("illegal_code", dut_vec(), 7'b0000101);
        fault_clr = 1'b1;
        drive(1, 0, 4);
        check("clr_blocked", dut_vec(), 7'b0000101);
        drive(0, 0, 3);
        check("clr_ok", dut_vec(), 7'b0000000);
        fault_clr = 1'b0;

        // on-time watchdog
        max_on = 10'd6;
        drive(1, 0, 15);
        check("watchdog_code", dut_vec(), 7'b0000110);
        fault_clr = 1'b1;
        drive(0, 0, 3);
        fault_clr = 1'b0;
        max_on = 10'd0;
        drive(1, 0, 40);
        check("no_watchdog", dut_vec(), 7'b1001000);
        drive(0, 0, 5);

        // enable gating
        dead_cyc = 4'd5;
        drive(1, 0, 3);
        en = 1'b0;
        drive(1, 0, 4);
        drive(1, 1, 4);
        check("en0_no_fault", dut_vec(), 7'b0);
        en = 1'b1;
        drive(1, 1, 3);
        en = 1'b0;
        drive(0, 0, 4);
        check("fault_holds_en0", dut_vec(), 7'b0000101);
        en = 1'b1;
        fault_clr = 1'b1;
        drive(0, 0, 3);
        fault_clr = 1'b0;

        // randomized traffic
        for (int s = 0; s < 250; s++) begin
            int r;
            logic u, d;
            r = $urandom_range(99);
            if (r < 5)       {u, d} = 2'b11;
            else if (r < 40) {u, d} = 2'b10;
            else if (r < 75) {u, d} = 2'b01;
            else             {u, d} = 2'b00;
            en = ($urandom_range(99) >= 5);
            fault_clr = ($urandom_range(99) < 30);
            if ($urandom_range(9) == 0) dead_cyc = 4'($urandom_range(15));
            if ($urandom_range(9) == 0)
                max_on = ($urandom_range(2) == 0) ? 10'd0 : 10'($urandom_range(40, 1));
            drive(u, d, $urandom_range(15, 1));
        end

        repeat (2) @(negedge clk_dds);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
